// File: rtl/rgb2ycbcr_ctrl_if.sv
// rtl/rgb2ycbcr_ctrl_if.sv - pixel, converter and output stream signals of rgb2ycbcr_ctrl
// master is the controller's view; slave is the surrounding source/converter/sink.
interface rgb2ycbcr_ctrl_if;
  logic        s_valid;
  logic [23:0] s_data;
  logic        s_ready;
  logic        conv_enable;
  logic [23:0] conv_data_in;
  logic [23:0] conv_data_out;
  logic        m_valid;
  logic [23:0] m_data;
  logic        m_block_last;
  logic        m_frame_last;
  logic        m_ready;

  modport master (
    input  s_valid, s_data, conv_data_out, m_ready,
    output s_ready, conv_enable, conv_data_in, m_valid, m_data, m_block_last, m_frame_last
  );

  modport slave (
    output s_valid, s_data, conv_data_out, m_ready,
    input  s_ready, conv_enable, conv_data_in, m_valid, m_data, m_block_last, m_frame_last
  );
endinterface

// File: rtl/rgb2ycbcr_ctrl.sv
// rtl/rgb2ycbcr_ctrl.sv - stream sequencer for the rgb2ycbcr colour-space converter
// Tags pixels through the 3-stage converter and buffers results in a credit-protected FIFO.
module rgb2ycbcr_ctrl #(
  parameter int BLOCK_PIXELS = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          cfg_num_blocks,
  rgb2ycbcr_ctrl_if.master     bus,
  output logic                 busy,
  output logic                 done
);
  localparam int PIX_W = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 4) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [PIX_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [15:0]           blk_cnt_q, blk_cnt_d;
  logic [15:0]           num_blk_q, num_blk_d;
  logic [2:0]            tag_v_q, tag_v_d;
  logic [2:0]            tag_bl_q, tag_bl_d;
  logic [2:0]            tag_fl_q, tag_fl_d;
  logic [23:0]           fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_bl_q, fifo_fl_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic             s_ready_c;
  logic             accept;
  logic             pop;
  logic             push;
  logic             conv_en;
  logic             pix_last;
  logic             frm_last;
  logic             fifo_nonempty;
  logic [OCC_W-1:0] occ;

  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign pop           = fifo_nonempty && bus.m_ready;
  assign push          = tag_v_q[2];
  assign accept        = bus.s_valid && s_ready_c;
  assign conv_en       = accept || (|tag_v_q);
  assign pix_last      = (pix_cnt_q == PIX_W'(BLOCK_PIXELS - 1));
  assign frm_last      = pix_last && (blk_cnt_q == num_blk_q - 16'd1);

  // Every pixel already in the converter owns a FIFO slot, so the FIFO cannot overflow.
  always_comb begin
    occ = OCC_W'(fifo_cnt_q);
    for (int i = 0; i < 3; i++) begin
      occ = occ + OCC_W'(tag_v_q[i]);
    end
    occ = occ - OCC_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_num_blocks != 16'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (accept && frm_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!(|tag_v_q) && !fifo_nonempty) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    s_ready_c = 1'b0;
    case (state_q)
      S_RUN: begin
        busy      = 1'b1;
        s_ready_c = (occ < OCC_W'(FIFO_DEPTH));
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    blk_cnt_d = blk_cnt_q;
    num_blk_d = num_blk_q;
    if ((state_q == S_IDLE) && start) begin
      pix_cnt_d = '0;
      blk_cnt_d = '0;
      num_blk_d = cfg_num_blocks;
    end else if (accept) begin
      if (pix_last) begin
        pix_cnt_d = '0;
        blk_cnt_d = blk_cnt_q + 16'd1;
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end
  end

  // Tags shift in lockstep with the converter; a bubble enters with valid=0.
  always_comb begin
    tag_v_d  = tag_v_q;
    tag_bl_d = tag_bl_q;
    tag_fl_d = tag_fl_q;
    if (conv_en) begin
      tag_v_d  = {tag_v_q[1:0], accept};
      tag_bl_d = {tag_bl_q[1:0], accept && pix_last};
      tag_fl_d = {tag_fl_q[1:0], accept && frm_last};
    end else if (push) begin
      tag_v_d[2] = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_q  <= '0;
      blk_cnt_q  <= '0;
      num_blk_q  <= '0;
      tag_v_q    <= '0;
      tag_bl_q   <= '0;
      tag_fl_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      pix_cnt_q  <= pix_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      num_blk_q  <= num_blk_d;
      tag_v_q    <= tag_v_d;
      tag_bl_q   <= tag_bl_d;
      tag_fl_q   <= tag_fl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.conv_data_out;
      fifo_bl_q[wr_ptr_q]   <= tag_bl_q[2];
      fifo_fl_q[wr_ptr_q]   <= tag_fl_q[2];
    end
  end

  assign bus.s_ready      = s_ready_c;
  assign bus.conv_enable  = conv_en;
  assign bus.conv_data_in = accept ? bus.s_data : 24'h0;
  assign bus.m_valid      = fifo_nonempty;
  assign bus.m_data       = fifo_nonempty ? fifo_data_q[rd_ptr_q] : 24'h0;
  assign bus.m_block_last = fifo_nonempty && fifo_bl_q[rd_ptr_q];
  assign bus.m_frame_last = fifo_nonempty && fifo_fl_q[rd_ptr_q];

  assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

  assert property (@(posedge clk) disable iff (!rst)
    (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data)));
endmodule

// File: tb/tb_rgb2ycbcr_ctrl.sv
// tb/tb_rgb2ycbcr_ctrl.sv - self-checking bench for rgb2ycbcr_ctrl
// Includes a behavioural 3-stage converter with enable and an arithmetic reference model.
module tb_rgb2ycbcr_ctrl;
  localparam int BP = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_num_blocks = 16'd0;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  rgb2ycbcr_ctrl_if bus ();

  rgb2ycbcr_ctrl #(.BLOCK_PIXELS(BP), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_num_blocks (cfg_num_blocks),
    .bus            (bus),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ycc(input logic [23:0] rgb);
    int r, g, b, y, cb, cr;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    y  = (77 * r + 150 * g + 29 * b) >>> 8;
    cb = ((128 * b - 43 * r - 85 * g) >>> 8) + 128;
    cr = ((128 * r - 107 * g - 21 * b) >>> 8) + 128;
    if (y > 255) y = 255;
    if (y < 0) y = 0;
    if (cb > 255) cb = 255;
    if (cb < 0) cb = 0;
    if (cr > 255) cr = 255;
    if (cr < 0) cr = 0;
    return {cr[7:0], cb[7:0], y[7:0]};
  endfunction

  function automatic logic [25:0] exp_word(input logic [23:0] rgb, input int idx, input int total);
    logic fl, bl;
    fl = (idx == total - 1);
    bl = ((idx % BP) == BP - 1);
    return {fl, bl, ycc(rgb)};
  endfunction

  logic [23:0] cv0 = 24'h0, cv1 = 24'h0, cv2 = 24'h0;
  always @(posedge clk) begin
    if (bus.conv_enable) begin
      cv0 <= ycc(bus.conv_data_in);
      cv1 <= cv0;
      cv2 <= cv1;
    end
  end
  assign bus.conv_data_out = cv2;

  int          cyc = 0;
  logic [23:0] sent_q[$];
  int          acc_edge_q[$];
  logic [25:0] out_q[$];
  int          out_cyc_q[$];
  int          en_cnt, done_cnt, stall_cnt, acc_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready) begin
      acc_edge_q.push_back(cyc + 1);
      acc_cnt++;
    end
    if (bus.s_valid && !bus.s_ready) stall_cnt++;
    if (bus.m_valid && bus.m_ready) begin
      out_q.push_back({bus.m_frame_last, bus.m_block_last, bus.m_data});
      out_cyc_q.push_back(cyc);
    end
    if (bus.conv_enable) en_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    sent_q.delete();
    acc_edge_q.delete();
    out_q.delete();
    out_cyc_q.delete();
    en_cnt = 0;
    done_cnt = 0;
    stall_cnt = 0;
    acc_cnt = 0;
  endtask

  task automatic do_start(input logic [15:0] nb);
    start = 1'b1;
    cfg_num_blocks = nb;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int n, input int gap, input bit use_fix, input logic [23:0] fix, output int timeouts);
    bit got;
    int w;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (use_fix && i == 0) ? fix : 24'($urandom);
      got = 1'b0;
      w = 0;
      while (!got && w < 200) begin
        @(negedge clk);
        got = bus.s_ready;
        tick();
        w++;
      end
      bus.s_valid = 1'b0;
      if (!got) begin
        timeouts++;
        break;
      end
      sent_q.push_back(bus.s_data);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int w;
    w = 0;
    while (done_cnt == 0 && w < limit) begin
      tick();
      w++;
    end
    ok = (done_cnt != 0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 24'h0;
    bus.m_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.s_ready, bus.conv_enable, bus.m_valid, bus.m_block_last, bus.m_frame_last, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000", {bus.s_ready, bus.conv_enable, bus.m_valid, bus.m_block_last, bus.m_frame_last, busy, done});
    end
    checks++;
    if (bus.conv_data_in !== 24'h0 || bus.m_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 000000/000000", bus.conv_data_in, bus.m_data);
    end
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b s_ready=%b want 0/0", busy, bus.s_ready);
    end
  endtask

  task automatic test_single_pixel();
    int to;
    bit ok;
    clear_mon();
    bus.m_ready = 1'b1;
    do_start(16'd1);
    send(1, 0, 1'b1, 24'hFFFFFF, to);
    repeat (6) tick();
    checks++;
    if (out_q.size() != 1 || out_q[0][23:0] !== 24'h8080FF) begin
      errors++;
      $display("FAIL single_data count=%0d data=%h want 1/8080ff", out_q.size(), (out_q.size() > 0) ? out_q[0][23:0] : 24'h0);
    end
    checks++;
    if (out_cyc_q.size() < 1 || acc_edge_q.size() < 1 || out_cyc_q[0] - acc_edge_q[0] != 3) begin
      errors++;
      $display("FAIL single_latency got %0d want 3", (out_cyc_q.size() > 0 && acc_edge_q.size() > 0) ? out_cyc_q[0] - acc_edge_q[0] : -1);
    end
    send(63, 0, 1'b0, 24'h0, to);
    wait_done(500, ok);
    checks++;
    if (!ok || to != 0 || out_q.size() != 64) begin
      errors++;
      $display("FAIL single_frame done=%0d timeouts=%0d outputs=%0d want 1/0/64", ok, to, out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word(sent_q[i], i, 64)) begin
        errors++;
        $display("FAIL single_pixel[%0d] got %h want %h", i, out_q[i], exp_word(sent_q[i], i, 64));
      end
    end
  endtask

  task automatic test_back_to_back();
    int to, bad;
    bit ok;
    clear_mon();
    bus.m_ready = 1'b1;
    do_start(16'd2);
    send(128, 0, 1'b0, 24'h0, to);
    wait_done(500, ok);
    checks++;
    if (stall_cnt != 0 || to != 0) begin
      errors++;
      $display("FAIL b2b_sready stalls=%0d timeouts=%0d want 0/0", stall_cnt, to);
    end
    checks++;
    if (!ok || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done pulses=%0d busy=%b want 1/0", done_cnt, busy);
    end
    checks++;
    if (out_q.size() != 128) begin
      errors++;
      $display("FAIL b2b_count got %0d want 128", out_q.size());
    end
    bad = 0;
    for (int i = 0; i < out_cyc_q.size() && i < acc_edge_q.size(); i++)
      if (out_cyc_q[i] - acc_edge_q[i] != 3) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_latency wrong=%0d want 0", bad);
    end
    for (int i = 0; i < out_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word(sent_q[i], i, 128)) begin
        errors++;
        $display("FAIL b2b_pixel[%0d] got %h want %h", i, out_q[i], exp_word(sent_q[i], i, 128));
      end
    end
  endtask

  task automatic test_backpressure();
    int to, n_acc;
    bit ok, rdy;
    clear_mon();
    bus.m_ready = 1'b0;
    do_start(16'd1);
    n_acc = 0;
    bus.s_valid = 1'b1;
    bus.s_data = 24'($urandom);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      tick();
      if (rdy) begin
        sent_q.push_back(bus.s_data);
        n_acc++;
        bus.s_data = 24'($urandom);
      end
    end
    checks++;
    if (n_acc != 4 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_credit accepted=%0d s_ready=%b want 4/0", n_acc, bus.s_ready);
    end
    checks++;
    if (bus.m_valid !== 1'b1 || sent_q.size() < 1 || bus.m_data !== ycc(sent_q[0])) begin
      errors++;
      $display("FAIL bp_head m_valid=%b m_data=%h want 1/%h", bus.m_valid, bus.m_data, (sent_q.size() > 0) ? ycc(sent_q[0]) : 24'h0);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    send(60, 0, 1'b0, 24'h0, to);
    wait_done(500, ok);
    checks++;
    if (!ok || to != 0 || out_q.size() != 64) begin
      errors++;
      $display("FAIL bp_frame done=%0d timeouts=%0d outputs=%0d want 1/0/64", ok, to, out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word(sent_q[i], i, 64)) begin
        errors++;
        $display("FAIL bp_pixel[%0d] got %h want %h", i, out_q[i], exp_word(sent_q[i], i, 64));
      end
    end
  endtask

  task automatic test_sparse();
    int to, bad;
    bit ok;
    clear_mon();
    bus.m_ready = 1'b1;
    do_start(16'd1);
    send(64, 4, 1'b0, 24'h0, to);
    wait_done(500, ok);
    checks++;
    if (!ok || to != 0 || out_q.size() != 64) begin
      errors++;
      $display("FAIL sparse_frame done=%0d timeouts=%0d outputs=%0d want 1/0/64", ok, to, out_q.size());
    end
    checks++;
    if (en_cnt != 4 * 64) begin
      errors++;
      $display("FAIL sparse_enable cycles got %0d want %0d", en_cnt, 4 * 64);
    end
    bad = 0;
    for (int i = 0; i < out_cyc_q.size() && i < acc_edge_q.size(); i++)
      if (out_cyc_q[i] - acc_edge_q[i] != 3) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sparse_latency wrong=%0d want 0", bad);
    end
    for (int i = 0; i < out_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word(sent_q[i], i, 64)) begin
        errors++;
        $display("FAIL sparse_pixel[%0d] got %h want %h", i, out_q[i], exp_word(sent_q[i], i, 64));
      end
    end
  endtask

  task automatic test_zero_blocks();
    clear_mon();
    bus.s_valid = 1'b1;
    bus.s_data = 24'($urandom);
    do_start(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done done=%b busy=%b want 1/1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle done=%b busy=%b want 0/0", done, busy);
    end
    repeat (4) tick();
    bus.s_valid = 1'b0;
    checks++;
    if (acc_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_accept accepted=%0d pulses=%0d want 0/1", acc_cnt, done_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    int to1, to2;
    bit ok;
    clear_mon();
    bus.m_ready = 1'b1;
    do_start(16'd2);
    send(10, 0, 1'b0, 24'h0, to1);
    do_start(16'd1);
    send(118, 0, 1'b0, 24'h0, to2);
    wait_done(500, ok);
    checks++;
    if (!ok || to1 + to2 != 0 || out_q.size() != 128 || done_cnt != 1) begin
      errors++;
      $display("FAIL restart_frame done=%0d timeouts=%0d outputs=%0d pulses=%0d want 1/0/128/1", ok, to1 + to2, out_q.size(), done_cnt);
    end
    for (int i = 0; i < out_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word(sent_q[i], i, 128)) begin
        errors++;
        $display("FAIL restart_pixel[%0d] got %h want %h", i, out_q[i], exp_word(sent_q[i], i, 128));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int to;
    bit ok;
    clear_mon();
    bus.m_ready = 1'b1;
    do_start(16'd1);
    send(30, 0, 1'b0, 24'h0, to);
    bus.s_valid = 1'b1;
    bus.s_data = 24'($urandom);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.conv_enable, bus.m_valid, bus.m_block_last, bus.m_frame_last, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_flags got %b want 0000000", {bus.s_ready, bus.conv_enable, bus.m_valid, bus.m_block_last, bus.m_frame_last, busy, done});
    end
    checks++;
    if (bus.conv_data_in !== 24'h0 || bus.m_data !== 24'h0) begin
      errors++;
      $display("FAIL midrst_data got %h/%h want 000000/000000", bus.conv_data_in, bus.m_data);
    end
    repeat (3) tick();
    rst = 1'b1;
    clear_mon();
    repeat (20) tick();
    bus.s_valid = 1'b0;
    checks++;
    if (out_q.size() != 0 || acc_cnt != 0) begin
      errors++;
      $display("FAIL midrst_quiet outputs=%0d accepted=%0d want 0/0", out_q.size(), acc_cnt);
    end
    clear_mon();
    do_start(16'd1);
    send(64, 0, 1'b0, 24'h0, to);
    wait_done(500, ok);
    checks++;
    if (!ok || to != 0 || out_q.size() != 64) begin
      errors++;
      $display("FAIL midrst_frame done=%0d timeouts=%0d outputs=%0d want 1/0/64", ok, to, out_q.size());
    end
    for (int i = 0; i < out_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_word(sent_q[i], i, 64)) begin
        errors++;
        $display("FAIL midrst_pixel[%0d] got %h want %h", i, out_q[i], exp_word(sent_q[i], i, 64));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 24'h0;
    bus.m_ready = 1'b1;
    #1;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_backpressure();
    test_sparse();
    test_zero_blocks();
    test_restart_ignored();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
